// File: rtl/light_conflict_monitor.sv
// Passive safety monitor for the intersection light bus: checks conflicts,
// colour sequencing and dwell limits, latches the first fault and drives flash-red.
module light_conflict_monitor #(
  parameter int CNT_W     = 5,
  parameter int YEL_MIN   = 2,
  parameter int GREEN_MAX = 15,
  parameter int FLASH_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       main_light,
  input  logic [1:0]       side_light,
  input  logic             walk_light,
  input  logic             fault_clr,
  output logic             armed,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             flash_en,
  output logic             flash_out,
  output logic [CNT_W-1:0] main_dwell,
  output logic [CNT_W-1:0] side_dwell
);

  typedef enum logic [1:0] {UNARMED, ARMED, FAULT} state_t;

  localparam logic [1:0] L_OFF = 2'd0;
  localparam logic [1:0] L_GRN = 2'd1;
  localparam logic [1:0] L_YEL = 2'd2;
  localparam logic [1:0] L_RED = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] YEL_MIN_C   = CNT_W'(YEL_MIN);
  localparam logic [CNT_W-1:0] GREEN_MAX_C = CNT_W'(GREEN_MAX);
  localparam int               DIV_W       = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(FLASH_DIV - 1);

  state_t           state, state_nxt;
  logic [1:0]       prev_main, prev_side;
  logic [CNT_W-1:0] main_dwell_nxt, side_dwell_nxt;
  logic [DIV_W-1:0] flash_div;
  logic [6:0]       viol;
  logic [2:0]       viol_code;

  function automatic logic is_go(input logic [1:0] c);
    return (c == L_GRN) || (c == L_YEL);
  endfunction

  // Changes to or from off are left to the dark check so they report as code 7.
  function automatic logic bad_step(input logic [1:0] from, input logic [1:0] to);
    return (to != from) && (from != L_OFF) && (to != L_OFF) &&
           !((from == L_GRN && to == L_YEL) ||
             (from == L_YEL && to == L_RED) ||
             (from == L_RED && to == L_GRN));
  endfunction

  function automatic logic [CNT_W-1:0] dwell_step(input logic [1:0] cur, input logic [1:0] prev,
                                                  input logic [CNT_W-1:0] dwell);
    if (cur != prev)       return CNT_W'(1);
    if (dwell == CNT_MAX)  return CNT_MAX;
    return dwell + 1'b1;
  endfunction

  assign main_dwell_nxt = dwell_step(main_light, prev_main, main_dwell);
  assign side_dwell_nxt = dwell_step(side_light, prev_side, side_dwell);

  // viol[i] corresponds to fault code i+1. Short yellow uses the pre-update
  // dwell; green stuck counts the current sample too.
  assign viol[0] = is_go(main_light) && is_go(side_light);
  assign viol[1] = bad_step(prev_main, main_light);
  assign viol[2] = bad_step(prev_side, side_light);
  assign viol[3] = walk_light && ((main_light != L_RED) || (side_light != L_RED));
  assign viol[4] = (prev_main == L_YEL && main_light == L_RED && main_dwell < YEL_MIN_C) ||
                   (prev_side == L_YEL && side_light == L_RED && side_dwell < YEL_MIN_C);
  assign viol[5] = (main_light == L_GRN && main_dwell_nxt >= GREEN_MAX_C) ||
                   (side_light == L_GRN && side_dwell_nxt >= GREEN_MAX_C);
  assign viol[6] = (main_light == L_OFF) || (side_light == L_OFF);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    viol_code = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (viol[i]) viol_code = 3'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) state <= UNARMED;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      UNARMED: if (main_light != L_OFF && side_light != L_OFF) state_nxt = ARMED;
      ARMED:   if (fault_clr)              state_nxt = UNARMED;
               else if (viol_code != 3'd0) state_nxt = FAULT;
      FAULT:   if (fault_clr)              state_nxt = UNARMED;
      default:                             state_nxt = UNARMED;
    endcase
  end

  always_comb begin
    armed    = (state != UNARMED);
    flash_en = (state == FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_main  <= L_OFF;
      prev_side  <= L_OFF;
      main_dwell <= '0;
      side_dwell <= '0;
      fault      <= 1'b0;
      fault_code <= 3'd0;
      flash_out  <= 1'b0;
      flash_div  <= '0;
    end else begin
      prev_main  <= main_light;
      prev_side  <= side_light;
      main_dwell <= main_dwell_nxt;
      side_dwell <= side_dwell_nxt;

      if (state_nxt == UNARMED) begin
        fault      <= 1'b0;
        fault_code <= 3'd0;
      end else if (state == ARMED && state_nxt == FAULT) begin
        fault      <= 1'b1;
        fault_code <= viol_code;
      end

      // flash_out starts high on entry and toggles every FLASH_DIV cycles after.
      if (state_nxt != FAULT) begin
        flash_out <= 1'b0;
        flash_div <= '0;
      end else if (state != FAULT) begin
        flash_out <= 1'b1;
        flash_div <= '0;
      end else if (flash_div == DIV_LAST) begin
        flash_out <= ~flash_out;
        flash_div <= '0;
      end else begin
        flash_div <= flash_div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Self-checking bench for light_conflict_monitor: table-driven vectors through
// a scoreboard queue, plus hand sequences for the legal cycle and saturation.
module tb_light_conflict_monitor;

  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       main_light, side_light;
  logic             walk_light, fault_clr;
  logic             armed, fault, flash_en, flash_out;
  logic [2:0]       fault_code;
  logic [CNT_W-1:0] main_dwell, side_dwell;

  always #5 clk = ~clk;

  light_conflict_monitor #(.CNT_W(CNT_W), .YEL_MIN(2), .GREEN_MAX(15), .FLASH_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .main_light(main_light), .side_light(side_light),
    .walk_light(walk_light), .fault_clr(fault_clr),
    .armed(armed), .fault(fault), .fault_code(fault_code),
    .flash_en(flash_en), .flash_out(flash_out),
    .main_dwell(main_dwell), .side_dwell(side_dwell)
  );

  typedef struct {
    logic rst, clr;
    logic [1:0] m, s;
    logic w;
    logic e_armed, e_fault;
    logic [2:0] e_code;
    logic e_fen, e_fout;
  } vec_t;

  typedef struct {
    int tag;
    logic armed, fault;
    logic [2:0] code;
    logic fen, fout;
    int md, sd;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference dwell model
  int         mdl_md = 0, mdl_sd = 0;
  logic [1:0] mdl_lm = 2'd0, mdl_ls = 2'd0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int rst, input int clr, input int m, input int s, input int w,
                              input int ea, input int ef, input int ec, input int efe, input int efo);
    vec_t v;
    v.rst = 1'(rst); v.clr = 1'(clr); v.m = 2'(m); v.s = 2'(s); v.w = 1'(w);
    v.e_armed = 1'(ea); v.e_fault = 1'(ef); v.e_code = 3'(ec);
    v.e_fen = 1'(efe); v.e_fout = 1'(efo);
    return v;
  endfunction

  task automatic apply(input vec_t v, input int tag);
    exp_t e;
    @(negedge clk);
    reset = v.rst; fault_clr = v.clr; main_light = v.m; side_light = v.s; walk_light = v.w;
    if (v.rst) begin
      mdl_md = 0; mdl_sd = 0; mdl_lm = 2'd0; mdl_ls = 2'd0;
    end else begin
      mdl_md = (v.m == mdl_lm) ? ((mdl_md == CNT_MAX) ? CNT_MAX : mdl_md + 1) : 1;
      mdl_sd = (v.s == mdl_ls) ? ((mdl_sd == CNT_MAX) ? CNT_MAX : mdl_sd + 1) : 1;
      mdl_lm = v.m; mdl_ls = v.s;
    end
    e.tag = tag; e.armed = v.e_armed; e.fault = v.e_fault; e.code = v.e_code;
    e.fen = v.e_fen; e.fout = v.e_fout; e.md = mdl_md; e.sd = mdl_sd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check($sformatf("t%0d.scoreboard_empty", tag), 0, 1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("t%0d.armed", e.tag),      int'(armed),      int'(e.armed));
      check($sformatf("t%0d.fault", e.tag),      int'(fault),      int'(e.fault));
      check($sformatf("t%0d.fault_code", e.tag), int'(fault_code), int'(e.code));
      check($sformatf("t%0d.flash_en", e.tag),   int'(flash_en),   int'(e.fen));
      check($sformatf("t%0d.flash_out", e.tag),  int'(flash_out),  int'(e.fout));
      check($sformatf("t%0d.main_dwell", e.tag), int'(main_dwell), e.md);
      check($sformatf("t%0d.side_dwell", e.tag), int'(side_dwell), e.sd);
    end
  endtask

  initial begin
    int pm[4] = '{3, 1, 2, 3};
    int ps[4] = '{2, 3, 3, 1};
    int pl[4] = '{3, 7, 3, 7};
    int fo[9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    int cyc;

    reset = 1'b1; fault_clr = 1'b0; main_light = 2'd0; side_light = 2'd0; walk_light = 1'b0;

    // Directed table, run after the legal cycle leaves the monitor ARMED on R/G.
    vecs.push_back(mk(0,0, 1,1,0, 1,1,1,1,1));             // conflict -> code 1
    for (int i = 1; i < 9; i++)
      vecs.push_back(mk(0,0, 3,3,0, 1,1,1,1,fo[i]));       // flash pattern
    vecs.push_back(mk(0,1, 3,3,0, 0,0,0,0,0));             // clear
    vecs.push_back(mk(0,0, 3,3,0, 1,0,0,0,0));             // re-arm
    vecs.push_back(mk(0,0, 1,2,1, 1,1,1,1,1));             // code 1 beats 3 and 4
    vecs.push_back(mk(0,1, 3,3,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0, 3,3,0, 1,0,0,0,0));
    vecs.push_back(mk(0,0, 1,3,0, 1,0,0,0,0));             // R->G legal
    vecs.push_back(mk(0,0, 3,3,0, 1,1,2,1,1));             // G->R illegal -> code 2
    vecs.push_back(mk(0,1, 3,3,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0, 3,3,0, 1,0,0,0,0));
    vecs.push_back(mk(0,0, 1,3,0, 1,0,0,0,0));
    vecs.push_back(mk(0,0, 2,3,0, 1,0,0,0,0));             // yellow for one sample
    vecs.push_back(mk(0,0, 3,3,0, 1,1,5,1,1));             // short yellow -> code 5
    vecs.push_back(mk(0,1, 3,3,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0, 3,3,0, 1,0,0,0,0));
    vecs.push_back(mk(0,1, 1,1,0, 0,0,0,0,0));             // clear beats conflict
    vecs.push_back(mk(0,0, 3,3,0, 1,0,0,0,0));
    for (int i = 1; i <= 15; i++)                          // green stuck on 15th sample
      vecs.push_back(mk(0,0, 1,3,0, 1, (i==15), (i==15) ? 6 : 0, (i==15), (i==15)));
    vecs.push_back(mk(0,1, 3,3,0, 0,0,0,0,0));
    vecs.push_back(mk(0,0, 3,3,0, 1,0,0,0,0));             // re-arm on next legal sample
    vecs.push_back(mk(0,0, 1,3,1, 1,1,4,1,1));             // walk conflict -> code 4
    vecs.push_back(mk(0,0, 1,1,0, 1,1,4,1,1));             // later conflict ignored
    vecs.push_back(mk(1,0, 0,0,0, 0,0,0,0,0));             // reset mid-FAULT
    vecs.push_back(mk(0,1, 3,3,0, 1,0,0,0,0));             // clear while unarmed: arms normally
    vecs.push_back(mk(0,0, 3,0,0, 1,1,7,1,1));             // dark -> code 7
    vecs.push_back(mk(1,0, 0,0,0, 0,0,0,0,0));

    apply(mk(1,0, 0,0,0, 0,0,0,0,0), 0);
    apply(mk(1,0, 0,0,0, 0,0,0,0,0), 1);

    // Legal cycle for 200 samples; arms on the first sample.
    cyc = 0;
    for (int r = 0; r < 10; r++) begin
      for (int p = 0; p < 4; p++) begin
        for (int k = 0; k < pl[p]; k++) begin
          apply(mk(0,0, pm[p],ps[p],0, 1,0,0,0,0), 1000 + cyc);
          if (p == 1 && k == 6) check($sformatf("legal%0d.green_dwell", cyc), int'(main_dwell), 7);
          cyc++;
        end
      end
    end

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 100 + i);

    // Dwell saturation while unarmed (side dark keeps the monitor disarmed).
    for (int i = 0; i < 36; i++) apply(mk(0,0, 3,0,0, 0,0,0,0,0), 2000 + i);
    check("sat.main_dwell", int'(main_dwell), CNT_MAX);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
